// File: rtl/serial_parity_tx_if.sv
// ---------------------------------------------------------------------------
// serial_parity_tx_if
// Bundles the parallel-word handshake and the serial output of the
// parity-framing transmitter.
//   din       : parallel word offered by the producer
//   load      : producer valid; a word is taken when load && ready
//   ready     : transmitter can take a word this cycle
//   out       : serial data / parity bit
//   out_valid : out carries a data or parity bit
//   last      : out carries the parity bit (final bit of the frame)
// master = producer / line observer, slave = transmitter.
// ---------------------------------------------------------------------------
interface serial_parity_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             load;
  logic             ready;
  logic             out;
  logic             out_valid;
  logic             last;

  modport master (
    output din, load,
    input  ready, out, out_valid, last
  );

  modport slave (
    input  din, load,
    output ready, out, out_valid, last
  );
endinterface

// File: rtl/serial_parity_tx.sv
// ---------------------------------------------------------------------------
// serial_parity_tx
// Takes a parallel word over a valid/ready handshake and sends it MSB first,
// one bit per clock, followed by a single parity bit. A new word may be
// accepted during the parity cycle, so back-to-back frames have no gap.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset, clears all state and outputs
//   bus  : slave side of serial_parity_tx_if (din, load in; ready, out,
//          out_valid, last out)
// Parameters:
//   WIDTH : data bits per frame (>= 2)
//   ODD   : 0 = even parity, 1 = odd parity
// ---------------------------------------------------------------------------
module serial_parity_tx #(
  parameter int WIDTH = 8,
  parameter bit ODD   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  serial_parity_tx_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             par_q,   par_d;
  logic             out_q,   out_d;
  logic             vld_q,   vld_d;
  logic             last_q,  last_d;

  logic             ready;
  logic             accept;
  logic             nxt_bit;

  assign ready   = (state_q == S_IDLE) || (state_q == S_PARITY);
  assign accept  = bus.load && ready;
  // shreg_q[WIDTH-1] is the bit currently on the line; the one below it is next
  assign nxt_bit = shreg_q[WIDTH-2];

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    out_d   = 1'b0;
    vld_d   = 1'b0;
    last_d  = 1'b0;

    if (accept) begin
      // MSB goes out on the accepting edge itself; cnt counts bits still to send
      state_d = S_DATA;
      shreg_d = bus.din;
      cnt_d   = CNT_W'(WIDTH - 1);
      par_d   = ODD ^ bus.din[WIDTH-1];
      out_d   = bus.din[WIDTH-1];
      vld_d   = 1'b1;
    end else begin
      case (state_q)
        S_DATA: begin
          if (cnt_q != '0) begin
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q - 1'b1;
            par_d   = par_q ^ nxt_bit;
            out_d   = nxt_bit;
            vld_d   = 1'b1;
          end else begin
            // din[0] has been on the line for one cycle; emit parity
            state_d = S_PARITY;
            out_d   = par_q;
            vld_d   = 1'b1;
            last_d  = 1'b1;
          end
        end
        S_PARITY: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      out_q   <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

  assign bus.ready     = ready;
  assign bus.out       = out_q;
  assign bus.out_valid = vld_q;
  assign bus.last      = last_q;

endmodule

// File: tb/tb_serial_parity_tx.sv
module tb_serial_parity_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  serial_parity_tx_if #(.WIDTH(8)) if0 ();
  serial_parity_tx_if #(.WIDTH(8)) if1 ();

  serial_parity_tx #(.WIDTH(8), .ODD(1'b0)) u_even (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  serial_parity_tx #(.WIDTH(8), .ODD(1'b1)) u_odd (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string      name;
    logic [7:0] din;
    bit         odd;
    logic [8:0] bits;   // expected line bits, [8] first ... [0] = parity
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic drive(input bit odd, input logic [7:0] d, input logic l);
    if (odd) begin
      if1.din  = d;
      if1.load = l;
    end else begin
      if0.din  = d;
      if0.load = l;
    end
  endtask

  task automatic sample(input bit odd, output logic o, output logic v,
                        output logic l, output logic r);
    if (odd) begin
      o = if1.out; v = if1.out_valid; l = if1.last; r = if1.ready;
    end else begin
      o = if0.out; v = if0.out_valid; l = if0.last; r = if0.ready;
    end
  endtask

  task automatic chk_idle(input string nm, input bit odd);
    logic o, v, l, r;
    sample(odd, o, v, l, r);
    chk($sformatf("%s idle out", nm),   32'(o), 32'd0);
    chk($sformatf("%s idle vld", nm),   32'(v), 32'd0);
    chk($sformatf("%s idle last", nm),  32'(l), 32'd0);
    chk($sformatf("%s idle ready", nm), 32'(r), 32'd1);
  endtask

  task automatic chk_bit(input string nm, input bit odd, input int c,
                         input logic eo, input logic el, input logic er);
    logic o, v, l, r;
    sample(odd, o, v, l, r);
    chk($sformatf("%s c%0d out", nm, c),   32'(o), 32'(eo));
    chk($sformatf("%s c%0d vld", nm, c),   32'(v), 32'd1);
    chk($sformatf("%s c%0d last", nm, c),  32'(l), 32'(el));
    chk($sformatf("%s c%0d ready", nm, c), 32'(r), 32'(er));
  endtask

  // One single-cycle-load frame; poke>0 pulses load with 8'hFF after the
  // check of that cycle, which must be ignored while the frame is busy.
  task automatic send(input string nm, input logic [7:0] d, input bit odd,
                      input logic [8:0] bits, input int poke);
    @(negedge clk);
    drive(odd, d, 1'b1);
    @(posedge clk); #1;
    drive(odd, d, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      chk_bit(nm, odd, c, bits[9-c], (c == 9), (c == 9));
      if (poke != 0 && c == poke)     drive(odd, 8'hFF, 1'b1);
      if (poke != 0 && c == poke + 1) drive(odd, 8'hFF, 1'b0);
    end
    @(posedge clk); #1;
    chk_idle(nm, odd);
  endtask

  initial begin
    logic [17:0] b2b;
    logic        o, v, l, r;

    vecs[0] = '{name: "even_B4", din: 8'hB4, odd: 1'b0, bits: 9'b1011_0100_0};
    vecs[1] = '{name: "even_07", din: 8'h07, odd: 1'b0, bits: 9'b0000_0111_1};
    vecs[2] = '{name: "odd_07",  din: 8'h07, odd: 1'b1, bits: 9'b0000_0111_0};
    vecs[3] = '{name: "odd_00",  din: 8'h00, odd: 1'b1, bits: 9'b0000_0000_1};
    vecs[4] = '{name: "even_FF", din: 8'hFF, odd: 1'b0, bits: 9'b1111_1111_0};
    vecs[5] = '{name: "odd_A5",  din: 8'hA5, odd: 1'b1, bits: 9'b1010_0101_1};

    drive(1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'h00, 1'b0);

    // reset for two cycles, then idle with load held low
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_idle($sformatf("rst_e%0d", i), 1'b0);
      chk_idle($sformatf("rst_o%0d", i), 1'b1);
    end

    // directed frames
    for (int i = 0; i < 6; i++)
      send(vecs[i].name, vecs[i].din, vecs[i].odd, vecs[i].bits, 0);

    // back-to-back: load held high, next word offered during the parity cycle
    b2b = {9'b1011_0100_0, 9'b0000_0111_1};
    @(negedge clk);
    drive(1'b0, 8'hB4, 1'b1);
    @(posedge clk); #1;
    for (int c = 1; c <= 18; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      chk_bit("b2b", 1'b0, c, b2b[18-c], (c == 9 || c == 18), (c == 9 || c == 18));
      if (c == 9)  drive(1'b0, 8'h07, 1'b1);
      if (c == 10) drive(1'b0, 8'h07, 1'b0);
    end
    @(posedge clk); #1;
    chk_idle("b2b", 1'b0);

    // busy rejection: 8'hFF pulsed during cycle 3 of the B4 frame
    send("busy", 8'hB4, 1'b0, 9'b1011_0100_0, 3);
    @(posedge clk); #1;
    chk_idle("busy_after", 1'b0);

    // asynchronous reset during cycle 4 of a frame
    @(negedge clk);
    drive(1'b0, 8'hB4, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 8'hB4, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      chk_bit("pre_rst", 1'b0, c, (c == 1 || c == 3 || c == 4), 1'b0, 1'b0);
    end
    #2;
    rst = 1'b1;
    #1;
    chk_idle("async_rst", 1'b0);
    @(posedge clk); #1;
    chk_idle("rst_hold", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    sample(1'b0, o, v, l, r);
    chk("post_rst vld", 32'(v), 32'd0);
    send("post_rst_07", 8'h07, 1'b0, 9'b0000_0111_1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_parity_tx.md
Name: serial_parity_tx

Overview:
Parity-framing serial transmitter. It accepts a parallel data word over a valid/ready handshake and shifts it out one bit per clock, MSB first. It then appends one parity bit. It produces the single-bit stream that the team's serial parity detector consumes. It sits between a parallel producer and the serial line feeding the detector.

Parameters:
WIDTH, 8, number of data bits per frame (>=2).
ODD, 0, 0 = even parity (data bits plus parity bit has an even number of ones); 1 = odd parity.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
din  input  WIDTH  parallel word to send; sampled only on an accepted load.
load  input  1  producer valid; word accepted on a rising edge where load && ready.
ready  output  1  block can accept a word this cycle (combinational from state).
out  output  1  registered serial data/parity bit.
out_valid  output  1  registered; high while out carries a data or parity bit.
last  output  1  registered; high only during the parity-bit cycle.

Behaviour:
- Reset (asserted at any time, including mid-frame): state=IDLE; shift register, bit counter and running parity cleared; out=0, out_valid=0, last=0. The in-flight frame is abandoned. After deassertion the block is in IDLE with ready=1.
- States: IDLE, DATA, PARITY.
- ready = 1 in IDLE and in PARITY, 0 in DATA.
- IDLE:
  - out=0, out_valid=0, last=0.
  - On accept, at the next edge: go to DATA, capture din, drive out=din[WIDTH-1], out_valid=1, count=WIDTH-1 remaining, parity accumulator = ODD ^ din[WIDTH-1].
  - Latency from the accepting edge to the first bit is zero extra cycles: the first bit is visible right after that edge.
- DATA:
  - Each edge shifts the next lower bit onto out and XORs it into the accumulator.
  - After din[0] has been driven for one cycle, the next edge goes to PARITY.
  - In PARITY, out = accumulated parity (ODD ^ XOR of all data bits), out_valid=1, last=1.
  - load is ignored in DATA (ready=0); din may change freely.
- PARITY:
  - Lasts exactly one cycle.
  - If load is high at that edge: the next word is accepted and behaves as an accept from IDLE. Its MSB follows the parity bit with no gap, so a new frame starts every WIDTH+1 cycles.
  - Otherwise: return to IDLE, with out=0, out_valid=0, last=0.
- Frame length is exactly WIDTH+1 consecutive out_valid cycles.
- Counter width is clog2(WIDTH)+1 bits; no wrap-around is visible externally.
- All outputs except ready come from flops, so there are no combinational paths from inputs to out, out_valid or last.
- din is captured only on the accepting edge; later changes to din do not affect the frame in flight.

Test Plan:
- rst=1 for 2 cycles, then release -> out=0, out_valid=0, last=0, ready=1. Holding load=0 keeps all outputs unchanged.
- WIDTH=8, ODD=0, din=8'hB4 with a one-cycle load -> out sequence 1,0,1,1,0,1,0,0 then parity 0. out_valid=1 for 9 cycles. last=1 only on the 9th cycle. ready=0 for cycles 1-8 and ready=1 on cycle 9.
- WIDTH=8, ODD=0, din=8'h07 -> data 0,0,0,0,0,1,1,1 then parity 1. Same din with ODD=1 -> parity 0. ODD=1 with din=8'h00 -> parity 1.
- Back-to-back: load held high with din=8'hB4, then din=8'h07 presented during the parity cycle -> 18 contiguous out_valid cycles, parity bits 0 then 1, and no IDLE cycle between the frames.
- Busy rejection: pulse load with din=8'hFF during cycle 3 of a frame for 8'hB4 -> the 8'hB4 frame is unchanged, 8'hFF is never sent, and the block returns to IDLE after the parity cycle.
- Reset mid-frame: assert rst asynchronously (between clock edges) during cycle 4 of a frame -> out, out_valid and last go to 0 immediately, without waiting for an edge. After release, the next accepted word 8'h07 is sent cleanly with parity 1.
